// File: rtl/traffic_phase_ctrl_if.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl_if
//
// Bundles the sensor inputs, lamp outputs and debug observation signals of
// traffic_phase_ctrl. Clock and reset stay plain ports on the controller.
//
// Signalling: there is no valid/ready handshake on this bus. req and
// flash_req are level inputs sampled on every clk edge (a one-cycle req pulse
// is enough to register demand). lights, phase_o, flash_o, state_dbg and
// pend_dbg are registered levels that are valid on every cycle.
//
// Signals:
//   req        [NUM_PHASES]   per-phase vehicle sensor (synchronised)
//   flash_req                 request flashing-yellow maintenance mode
//   lights     [3*NUM_PHASES] lamp field, phase k on bits [3k+2:3k]
//   phase_o    [3]            phase owning green / yellow / all-red
//   flash_o                   high while in FLASH
//   state_dbg  [2]            controller state (0 green, 1 yellow, 2 all-red, 3 flash)
//   pend_dbg   [NUM_PHASES]   latched demand register
//
// Modports: master = sensor/observer side, slave = controller side.
// -----------------------------------------------------------------------------
interface traffic_phase_ctrl_if #(
    parameter int NUM_PHASES = 4
);
    logic [NUM_PHASES-1:0]   req;
    logic                    flash_req;
    logic [3*NUM_PHASES-1:0] lights;
    logic [2:0]              phase_o;
    logic                    flash_o;
    logic [1:0]              state_dbg;
    logic [NUM_PHASES-1:0]   pend_dbg;

    modport master (
        output req,
        output flash_req,
        input  lights,
        input  phase_o,
        input  flash_o,
        input  state_dbg,
        input  pend_dbg
    );

    modport slave (
        input  req,
        input  flash_req,
        output lights,
        output phase_o,
        output flash_o,
        output state_dbg,
        output pend_dbg
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
//
// Sensor-actuated signal controller for NUM_PHASES conflicting approaches.
// Phase 0 (main road) rests in green without demand; other phases are served
// round-robin on latched demand with min/max green, yellow and all-red
// clearance. flash_req brings the junction safely into flashing yellow.
// All timing is counted in ticks of a free-running 1 s prescaler.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    traffic_phase_ctrl_if.slave (req, flash_req in; lights, phase_o,
//          flash_o, state_dbg, pend_dbg out)
// -----------------------------------------------------------------------------
module traffic_phase_ctrl #(
    parameter int NUM_PHASES  = 4,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int GREEN_MIN_S = 5,
    parameter int GREEN_MAX_S = 20,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_phase_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    // el must reach every duration it is compared against, so it saturates
    // at the largest of them (GREEN_MAX_S for sane parameter sets).
    localparam int EL_MAX_A = (GREEN_MAX_S > YELLOW_S) ? GREEN_MAX_S : YELLOW_S;
    localparam int EL_MAX   = (EL_MAX_A > ALLRED_S) ? EL_MAX_A : ALLRED_S;
    localparam int EL_W     = $clog2(EL_MAX + 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    localparam logic [3*NUM_PHASES-1:0] LIGHTS_RST = {{(NUM_PHASES-1){LAMP_RED}}, LAMP_GREEN};

    state_t                  state_q, state_d;
    logic [2:0]              p_q, p_d;
    logic [2:0]              nxt_q, nxt_d;
    logic [NUM_PHASES-1:0]   pend_q, pend_d;
    logic [EL_W-1:0]         el_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    fl_q, fl_d;     // flash lamp phase: 1 = yellow, 0 = dark
    logic [3*NUM_PHASES-1:0] lights_q, lights_d;
    logic                    flash_q;
    logic                    tick;
    logic                    enter;          // any state entry this cycle

    assign tick = (cnt_q == CNT_W'(TICK_CYCLES - 1));

    // Free-running prescaler: never restarted by state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            el_q <= '0;
        end else if (enter) begin
            el_q <= '0;
        end else if (tick && (el_q != EL_W'(EL_MAX))) begin
            el_q <= el_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_GREEN;
            p_q      <= '0;
            nxt_q    <= '0;
            pend_q   <= '0;
            fl_q     <= 1'b0;
            lights_q <= LIGHTS_RST;
            flash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            nxt_q    <= nxt_d;
            pend_q   <= pend_d;
            fl_q     <= fl_d;
            lights_q <= lights_d;
            flash_q  <= (state_d == ST_FLASH);
        end
    end

    always_comb begin
        logic                  req_p;
        logic                  others;
        logic                  found;
        logic [2:0]            sel;
        logic                  green_done;
        int                    idx;

        state_d  = state_q;
        p_d      = p_q;
        nxt_d    = nxt_q;
        fl_d     = fl_q;
        enter    = 1'b0;
        pend_d   = pend_q;
        lights_d = lights_q;
        req_p    = 1'b0;
        others   = 1'b0;
        found    = 1'b0;
        sel      = '0;
        idx      = 0;

        for (int k = 0; k < NUM_PHASES; k++) begin
            if (p_q == 3'(k)) begin
                req_p = bus.req[k];
            end else if (pend_q[k]) begin
                others = 1'b1;
            end
        end

        // Round-robin pick starting after the current phase; 0 if nobody waits.
        for (int i = 1; i < NUM_PHASES; i++) begin
            idx = int'(p_q) + i;
            if (idx >= NUM_PHASES) begin
                idx = idx - NUM_PHASES;
            end
            for (int k = 0; k < NUM_PHASES; k++) begin
                if ((k == idx) && pend_q[k] && !found) begin
                    sel   = 3'(k);
                    found = 1'b1;
                end
            end
        end

        // el >= MAX-1 (not ==) so a green that already saturated el still
        // yields when demand shows up late.
        green_done = bus.flash_req
                   || (others && (!req_p || (int'(el_q) >= GREEN_MAX_S - 1)))
                   || ((p_q != 3'd0) && !others && !req_p);

        case (state_q)
            ST_GREEN: begin
                if (tick && (int'(el_q) >= GREEN_MIN_S - 1) && green_done) begin
                    state_d = ST_YELLOW;
                    nxt_d   = sel;
                    enter   = 1'b1;
                end
            end
            ST_YELLOW: begin
                if (tick && (int'(el_q) == YELLOW_S - 1)) begin
                    state_d = ST_ALLRED;
                    enter   = 1'b1;
                end
            end
            ST_ALLRED: begin
                if (tick && (int'(el_q) == ALLRED_S - 1)) begin
                    enter = 1'b1;
                    if (bus.flash_req) begin
                        state_d = ST_FLASH;
                        fl_d    = 1'b1;
                    end else begin
                        state_d = ST_GREEN;
                        p_d     = nxt_q;
                    end
                end
            end
            ST_FLASH: begin
                if (tick) begin
                    if (!bus.flash_req) begin
                        state_d = ST_ALLRED;
                        nxt_d   = '0;
                        fl_d    = 1'b0;
                        enter   = 1'b1;
                    end else begin
                        fl_d = ~fl_q;
                    end
                end
            end
            default: begin
                state_d = ST_GREEN;
                p_d     = '0;
                enter   = 1'b1;
            end
        endcase

        // Demand latch: set while not green, cleared on green entry (clear wins).
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (enter && (state_d == ST_GREEN) && (p_d == 3'(k))) begin
                pend_d[k] = 1'b0;
            end else if (bus.req[k] && !((state_q == ST_GREEN) && (p_q == 3'(k)))) begin
                pend_d[k] = 1'b1;
            end
        end

        // Lamps are decoded from the next state so they register with it.
        for (int k = 0; k < NUM_PHASES; k++) begin
            case (state_d)
                ST_GREEN:  lights_d[3*k +: 3] = (p_d == 3'(k)) ? LAMP_GREEN : LAMP_RED;
                ST_YELLOW: lights_d[3*k +: 3] = (p_d == 3'(k)) ? LAMP_YELLOW : LAMP_RED;
                ST_ALLRED: lights_d[3*k +: 3] = LAMP_RED;
                default:   lights_d[3*k +: 3] = fl_d ? LAMP_YELLOW : LAMP_DARK;
            endcase
        end
    end

    assign bus.lights    = lights_q;
    assign bus.phase_o   = p_q;
    assign bus.flash_o   = flash_q;
    assign bus.state_dbg = state_q;
    assign bus.pend_dbg  = pend_q;

endmodule
